// File: rtl/alu_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared types and constants for the ALU sharing arbiter.
//   alu_op_e     : ALU selector encodings understood by the downstream ALU
//   ALU_OP_MAX   : highest supported selector; anything above is an error op
//   arb_state_e  : sequencing states of the arbiter (one op in flight)
//   op_unsupported() : true when a selector has no ALU function behind it
// ---------------------------------------------------------------------------
package alu_share_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_OR_ALT = 4'd4,  // second OR encoding, kept for decoder compatibility
    ALU_XOR    = 4'd5,
    ALU_LSL    = 4'd6,
    ALU_LSR    = 4'd7,
    ALU_ASR    = 4'd8
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic op_unsupported(input logic [3:0] op);
    return (op > ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter, purely combinational.
//   req_i   [1:0] : request vector
//   last_i        : index of the requester granted most recently
//   grant_o [1:0] : one-hot grant, or zero when nothing is requested
// On a tie the requester that did not win last time is granted; a single
// request is always granted regardless of history.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two requesters. Requests are granted
// round-robin, the winning operands/selector are registered and driven to the
// ALU, the ALU result is registered with N/Z flags and held as a response
// until the consumer takes it. Exactly one operation is in flight.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   req_valid_i [2]     : request pending per requester
//   req_ready_o [2]     : request accepted this cycle (one-hot or zero)
//   req_op_i    [2][4]  : ALU selector per requester
//   req_a_i     [2][N]  : operand A per requester
//   req_b_i     [2][N]  : operand B / shift amount per requester
//   alu_sel_o/a_o/b_o   : captured selector/operands driven to the ALU
//   alu_y_i     [N]     : ALU result, combinational from alu_sel/a/b
//   rsp_valid_o         : response holding
//   rsp_ready_i         : consumer accepts the response
//   rsp_id_o            : requester that owns the response
//   rsp_y_o     [N]     : registered result (0 for unsupported ops)
//   rsp_n_o, rsp_z_o    : sign and zero flags of rsp_y_o
//   rsp_err_o           : selector was unsupported (> ALU_OP_MAX)
//   busy_o              : an operation is in flight
// ---------------------------------------------------------------------------
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N       = 8,
  parameter int NUM_REQ = 2   // fixed at 2: the arbiter is two-input
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0][3:0]       req_op_i,
  input  logic [NUM_REQ-1:0][N-1:0]     req_a_i,
  input  logic [NUM_REQ-1:0][N-1:0]     req_b_i,
  output logic [3:0]                    alu_sel_o,
  output logic [N-1:0]                  alu_a_o,
  output logic [N-1:0]                  alu_b_o,
  input  logic [N-1:0]                  alu_y_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          rsp_id_o,
  output logic [N-1:0]                  rsp_y_o,
  output logic                          rsp_n_o,
  output logic                          rsp_z_o,
  output logic                          rsp_err_o,
  output logic                          busy_o
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  arb_state_e         state_q,   state_d;
  logic               last_q,    last_d;
  logic [3:0]         op_q,      op_d;
  logic [N-1:0]       a_q,       a_d;
  logic [N-1:0]       b_q,       b_d;
  logic               id_q,      id_d;
  logic [N-1:0]       rsp_y_q,   rsp_y_d;
  logic               rsp_n_q,   rsp_n_d;
  logic               rsp_z_q,   rsp_z_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_id_q,  rsp_id_d;

  logic               capture_en;
  logic               result_en;

  // -------------------------------------------------------------------------
  // Arbitration: only requests seen in IDLE compete, which also keeps
  // req_ready low in every other state.
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;

  assign arb_req   = (state_q == ST_IDLE) ? req_valid_i : '0;
  assign grant_any = |grant;

  rr_arbiter2 u_rr (
    .req_i   (arb_req),
    .last_i  (last_q),
    .grant_o (grant)
  );

  // -------------------------------------------------------------------------
  // Operand select: grant is one-hot, so masking each requester's fields by
  // its grant bit and OR-ing them yields the winner's fields.
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0][3:0]   op_masked;
  logic [NUM_REQ-1:0][N-1:0] a_masked;
  logic [NUM_REQ-1:0][N-1:0] b_masked;
  logic [3:0]                op_sel;
  logic [N-1:0]              a_sel;
  logic [N-1:0]              b_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_mask
      assign op_masked[gi] = grant[gi] ? req_op_i[gi] : '0;
      assign a_masked[gi]  = grant[gi] ? req_a_i[gi]  : '0;
      assign b_masked[gi]  = grant[gi] ? req_b_i[gi]  : '0;
    end
  endgenerate

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_sel = op_sel | op_masked[i];
      a_sel  = a_sel  | a_masked[i];
      b_sel  = b_sel  | b_masked[i];
    end
  end

  // -------------------------------------------------------------------------
  // Sequencing FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    result_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          capture_en = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_en = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Capture and result next-state
  // -------------------------------------------------------------------------
  always_comb begin
    last_d    = last_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    rsp_y_d   = rsp_y_q;
    rsp_n_d   = rsp_n_q;
    rsp_z_d   = rsp_z_q;
    rsp_err_d = rsp_err_q;
    rsp_id_d  = rsp_id_q;

    if (capture_en) begin
      op_d   = op_sel;
      a_d    = a_sel;
      b_d    = b_sel;
      id_d   = grant[1];
      last_d = grant[1];
    end

    // Unsupported selectors still occupy the slot but report a zero result,
    // so flags come out as Z=1, N=0 without trusting the ALU output.
    if (result_en) begin
      rsp_err_d = op_unsupported(op_q);
      rsp_y_d   = rsp_err_d ? '0 : alu_y_i;
      rsp_n_d   = rsp_y_d[N-1];
      rsp_z_d   = (rsp_y_d == '0);
      rsp_id_d  = id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;  // requester 0 wins the first tie
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      rsp_y_q   <= '0;
      rsp_n_q   <= 1'b0;
      rsp_z_q   <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      last_q    <= last_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      rsp_y_q   <= rsp_y_d;
      rsp_n_q   <= rsp_n_d;
      rsp_z_q   <= rsp_z_d;
      rsp_err_q <= rsp_err_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: the ALU sees the captured registers in every state, so its
  // inputs only move when a new request is accepted.
  // -------------------------------------------------------------------------
  assign req_ready_o = grant;
  assign alu_sel_o   = op_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_y_o     = rsp_y_q;
  assign rsp_n_o     = rsp_n_q;
  assign rsp_z_o     = rsp_z_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
